// File: rtl/ps2_pkg.sv
// Shared PS/2 constants: prefix bytes, arrow scan codes, direction bit indices
// and the frame receiver state encoding.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam logic [7:0] PS2_BRK   = 8'hF0;

  localparam logic [7:0] KEY_RIGHT = 8'h74;
  localparam logic [7:0] KEY_LEFT  = 8'h6B;
  localparam logic [7:0] KEY_UP    = 8'h75;
  localparam logic [7:0] KEY_DOWN  = 8'h72;

  localparam int DIR_RIGHT = 0;
  localparam int DIR_LEFT  = 1;
  localparam int DIR_UP    = 2;
  localparam int DIR_DOWN  = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_t;

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame deserialiser: synchroniser, registered falling-edge detect, 11-bit
// frame FSM with odd-parity/stop check and mid-frame timeout.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYC = 10000,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       ps2_clk_i,
  input  logic       ps2_dat_i,
  output logic [7:0] byte_o,
  output logic       valid_o,
  output logic       err_o
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  logic [SYNC_STAGES-1:0] clk_sync_q, dat_sync_q;
  logic                   clk_prev_q, fall_q, bit_q;
  ps2_state_t             state_q, state_d;
  logic [2:0]             cnt_q, cnt_d;
  logic [7:0]             shift_q, shift_d;
  logic                   par_q, par_d;
  logic [CW-1:0]          tmo_q, tmo_d;
  logic [7:0]             byte_q, byte_d;
  logic                   valid_q, valid_d, err_q, err_d;
  logic                   tmo_hit, frame_ok;

  // Edge and sampled bit are registered together, so the FSM sees a one-cycle
  // event with its data bit aligned.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      clk_sync_q <= '1;
      dat_sync_q <= '1;
      clk_prev_q <= 1'b1;
      fall_q     <= 1'b0;
      bit_q      <= 1'b1;
    end else begin
      clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk_i};
      dat_sync_q <= {dat_sync_q[SYNC_STAGES-2:0], ps2_dat_i};
      clk_prev_q <= clk_sync_q[SYNC_STAGES-1];
      fall_q     <= clk_prev_q & ~clk_sync_q[SYNC_STAGES-1];
      bit_q      <= dat_sync_q[SYNC_STAGES-1];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tmo_q   <= '0;
      byte_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tmo_q   <= tmo_d;
      byte_q  <= byte_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  // A falling edge in the same cycle as the limit wins over the timeout.
  assign tmo_hit  = (state_q != ST_IDLE) && !fall_q && (tmo_q == CW'(TIMEOUT_CYC - 1));
  assign tmo_d    = ((state_q == ST_IDLE) || fall_q) ? '0 : tmo_q + CW'(1);
  assign frame_ok = bit_q && (^{shift_q, par_q});

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    par_d   = par_q;
    if (tmo_hit) begin
      state_d = ST_IDLE;
    end else if (fall_q) begin
      case (state_q)
        ST_IDLE: begin
          if (!bit_q) begin
            state_d = ST_SHIFT;
            cnt_d   = '0;
          end
        end
        ST_SHIFT: begin
          shift_d[cnt_q] = bit_q;
          cnt_d          = cnt_q + 3'd1;
          if (cnt_q == 3'd7) state_d = ST_PARITY;
        end
        ST_PARITY: begin
          par_d   = bit_q;
          state_d = ST_STOP;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    byte_d  = byte_q;
    valid_d = 1'b0;
    err_d   = tmo_hit;
    if (fall_q && (state_q == ST_STOP)) begin
      if (frame_ok) begin
        byte_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  assign byte_o  = byte_q;
  assign valid_o = valid_q;
  assign err_o   = err_q;

endmodule

// File: rtl/ps2_keypad_rx.sv
// PS/2 keyboard receiver with arrow-key make/break decoding into an active-low
// held-direction nibble; direction updates the cycle after scan_valid.
module ps2_keypad_rx
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYC = 10000,
  parameter int SYNC_STAGES = 2
) (
  input  logic       master_clk,
  input  logic       rst_n,
  input  logic       KB_clk,
  input  logic       data,
  output logic [7:0] scan_code,
  output logic       scan_valid,
  output logic       frame_err,
  output logic [3:0] direction
);

  logic [7:0] rx_byte;
  logic       rx_vld;
  logic       ext_q, ext_d, brk_q, brk_d;
  logic [3:0] dir_q, dir_d;

  ps2_frame_rx #(
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_frame_rx (
    .clk_i     (master_clk),
    .rst_ni    (rst_n),
    .ps2_clk_i (KB_clk),
    .ps2_dat_i (data),
    .byte_o    (rx_byte),
    .valid_o   (rx_vld),
    .err_o     (frame_err)
  );

  always_ff @(posedge master_clk) begin
    if (!rst_n) begin
      ext_q <= 1'b0;
      brk_q <= 1'b0;
      dir_q <= 4'b1111;
    end else begin
      ext_q <= ext_d;
      brk_q <= brk_d;
      dir_q <= dir_d;
    end
  end

  // Prefix bytes accumulate in either order; the next non-prefix byte consumes them.
  always_comb begin
    ext_d = ext_q;
    brk_d = brk_q;
    dir_d = dir_q;
    if (rx_vld) begin
      if (rx_byte == PS2_EXT) begin
        ext_d = 1'b1;
      end else if (rx_byte == PS2_BRK) begin
        brk_d = 1'b1;
      end else begin
        if (ext_q) begin
          case (rx_byte)
            KEY_RIGHT: dir_d[DIR_RIGHT] = brk_q;
            KEY_LEFT:  dir_d[DIR_LEFT]  = brk_q;
            KEY_UP:    dir_d[DIR_UP]    = brk_q;
            KEY_DOWN:  dir_d[DIR_DOWN]  = brk_q;
            default:   ;
          endcase
        end
        ext_d = 1'b0;
        brk_d = 1'b0;
      end
    end
  end

  assign scan_code  = rx_byte;
  assign scan_valid = rx_vld;
  assign direction  = dir_q;

endmodule
